// File: rtl/selector_arbiter.sv
// Round-robin arbiter sharing one address selector among N_REQ requesters.
// Each grant latches its address, waits a settle time, then drives sel_valid until released.
module selector_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [CNT_W-1:0]          settle_cycles,
  output logic [ADDR_W-1:0]         sel_addr,
  output logic                      sel_valid,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic                      busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  pick;
  logic [N_REQ-1:0]  pick_oh;
  logic [ADDR_W-1:0] pick_addr;
  logic              held;

  // gnt is one-hot of the current winner, so this is req[winner] while granted
  assign held = |(req & gnt);

  always_comb begin
    logic        found;
    int unsigned idx;
    found     = 1'b0;
    idx       = 0;
    pick      = '0;
    pick_oh   = '0;
    pick_addr = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        pick         = IDX_W'(idx);
        pick_oh[idx] = 1'b1;
        pick_addr    = req_addr[idx*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_addr  <= '0;
      sel_valid <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      last      <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            state    <= SETTLE;
            gnt      <= pick_oh;
            sel_addr <= pick_addr;
            cnt      <= settle_cycles;
            last     <= pick;
            busy     <= 1'b1;
          end
        end
        SETTLE: begin
          if (!held) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state     <= ACTIVE;
            sel_valid <= 1'b1;
            done      <= gnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACTIVE: begin
          done <= '0;
          if (!held) begin
            state     <= IDLE;
            gnt       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          done      <= '0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_selector_arbiter.sv
// Directed bench for selector_arbiter: one task per scenario, inline expected-value checks.
module tb_selector_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 14;
  localparam int unsigned CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [CW-1:0]   settle_cycles;
  logic [AW-1:0]   sel_addr;
  logic            sel_valid;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;

  int total = 0;
  int bad   = 0;

  selector_arbiter #(.N_REQ(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .settle_cycles(settle_cycles), .sel_addr(sel_addr), .sel_valid(sel_valid),
    .gnt(gnt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_addr = '0; settle_cycles = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sel_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sel_addr !== 14'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", sel_addr); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_noreq_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    req_addr[0*AW +: AW] = 14'd1; settle_cycles = 8'd3; req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL basic_gnt got=%b want=0001", gnt); end
    total++; if (sel_addr !== 14'd1) begin bad++; $display("FAIL basic_addr got=%0d want=1", sel_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    for (int i = 0; i < 3; i++) begin
      total++; if (sel_valid !== 1'b0 || done !== 4'b0000) begin bad++; $display("FAIL basic_settle%0d valid=%b done=%b want 0/0000", i, sel_valid, done); end
      tick();
    end
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL basic_settle3 valid=%b want=0", sel_valid); end
    tick();
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL basic_done got=%b want=0001", done); end
    total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", sel_valid); end
    tick();
    total++; if (done !== 4'b0000 || sel_valid !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL basic_active done=%b valid=%b gnt=%b want 0000/1/0001", done, sel_valid, gnt); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000 || sel_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_release gnt=%b valid=%b busy=%b want 0000/0/0", gnt, sel_valid, busy); end
    total++; if (sel_addr !== 14'd1) begin bad++; $display("FAIL basic_addr_hold got=%0d want=1", sel_addr); end
  endtask

  task automatic test_zero_settle();
    req_addr[2*AW +: AW] = 14'd16383; settle_cycles = 8'd0; req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL zs_gnt got=%b want=0100", gnt); end
    total++; if (sel_addr !== 14'd16383) begin bad++; $display("FAIL zs_addr got=%0d want=16383", sel_addr); end
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL zs_settle_valid got=%b want=0", sel_valid); end
    tick();
    total++; if (done !== 4'b0100 || sel_valid !== 1'b1) begin bad++; $display("FAIL zs_done done=%b valid=%b want 0100/1", done, sel_valid); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_w[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] oh;
    int n;
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    settle_cycles = 8'd1;
    for (int w = 0; w < N; w++) req_addr[w*AW +: AW] = AW'(w + 10);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      oh = '0; oh[exp_w[g]] = 1'b1;
      tick();
      total++; if (gnt !== oh) begin bad++; $display("FAIL rr_gnt%0d got=%b want=%b", g, gnt, oh); end
      n = 0;
      while (done === 4'b0000 && n < 20) begin tick(); n++; end
      total++; if (done !== oh) begin bad++; $display("FAIL rr_done%0d got=%b want=%b", g, done, oh); end
      total++; if (sel_addr !== AW'(exp_w[g] + 10)) begin bad++; $display("FAIL rr_addr%0d got=%0d want=%0d", g, sel_addr, exp_w[g] + 10); end
      tick();
      req = 4'b1111 & ~oh;
      tick();
      total++; if (gnt !== 4'b0000 || sel_valid !== 1'b0) begin bad++; $display("FAIL rr_break%0d gnt=%b valid=%b want 0000/0", g, gnt, sel_valid); end
      req = 4'b1111;
    end
    req = 4'b0000;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_abort();
    settle_cycles = 8'd5; req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL abort_gnt got=%b want=0010", gnt); end
    tick(); tick();
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin bad++; $display("FAIL abort_idle gnt=%b busy=%b done=%b want 0000/0/0000", gnt, busy, done); end
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL abort_next_gnt got=%b want=0001", gnt); end
    req = 4'b0000;
    tick();
    total++; if (done !== 4'b0000 || gnt !== 4'b0000) begin bad++; $display("FAIL abort2_idle done=%b gnt=%b want 0000/0000", done, gnt); end
  endtask

  task automatic test_latch();
    req_addr[1*AW +: AW] = 14'd100; settle_cycles = 8'd0; req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010 || sel_addr !== 14'd100) begin bad++; $display("FAIL latch_gnt gnt=%b addr=%0d want 0010/100", gnt, sel_addr); end
    tick();
    req_addr[1*AW +: AW] = 14'd200; settle_cycles = 8'd7; req = 4'b1110;
    tick(); tick();
    total++; if (sel_addr !== 14'd100) begin bad++; $display("FAIL latch_addr got=%0d want=100", sel_addr); end
    total++; if (sel_valid !== 1'b1 || gnt !== 4'b0010) begin bad++; $display("FAIL latch_hold valid=%b gnt=%b want 1/0010", sel_valid, gnt); end
    req = 4'b0000;
    tick();
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL latch_release valid=%b want=0", sel_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0]  oh;
    logic [AW-1:0] a;
    int w, n;
    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(0, N - 1));
      a = AW'($urandom_range(0, 16383));
      oh = '0; oh[w] = 1'b1;
      req_addr[w*AW +: AW] = a;
      settle_cycles = (i == 4) ? 8'd3 : CW'($urandom_range(0, 3));
      req = oh;
      tick();
      total++; if (gnt !== oh || sel_addr !== a) begin bad++; $display("FAIL rnd_gnt%0d gnt=%b addr=%0d want %b/%0d", i, gnt, sel_addr, oh, a); end
      if (i == 4) begin
        tick();
        rst = 1'b1;
        tick();
        total++; if ({gnt, done, sel_valid, busy} !== '0 || sel_addr !== 14'd0) begin bad++; $display("FAIL rnd_rst gnt=%b done=%b valid=%b busy=%b addr=%0d want all 0", gnt, done, sel_valid, busy, sel_addr); end
        rst = 1'b0; req = '0;
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rnd_rst_nodone got=%b want=0000", done); end
      end else begin
        n = 0;
        while (done === 4'b0000 && n < 10) begin tick(); n++; end
        total++; if (done !== oh || sel_addr !== a) begin bad++; $display("FAIL rnd_done%0d done=%b addr=%0d want %b/%0d", i, done, sel_addr, oh, a); end
        req = '0;
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_settle();
    test_round_robin();
    test_abort();
    test_latch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
